// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg
// Shared definitions for the UART receive path.
//   - rx_state_t  : receiver frame states (IDLE..STOP)
//   - PAR_EVEN/ODD: encoding of the parity-type select input
//   - sampleFirst/sampleMid/decideCount: bit-counter values at which the line
//     is sampled and the majority decision is taken, derived from the
//     oversampling ratio
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // First of the three samples, one count before mid-bit
    function automatic int sampleFirst(input int os);
        return os / 2 - 1;
    endfunction

    // Centre sample of the bit period
    function automatic int sampleMid(input int os);
        return os / 2;
    endfunction

    // Third sample; the majority vote is resolved on this count
    function automatic int decideCount(input int os);
        return os / 2 + 1;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// ============================================================================
// uart_rx_sampler
// Bit-period counter plus three-sample majority vote for the UART receiver.
// Ports:
//   i_clk      : clock, rising edge
//   i_rst      : synchronous active-high reset
//   i_rx       : synchronized serial line
//   i_start    : start-edge seen while idle; counter loads 1 (edge cycle = 0)
//   i_clear    : receiver returning to idle; counter cleared to 0
//   i_run      : receiver is inside a frame; counter advances
//   o_bitVal   : majority of the three samples (valid with o_bitDone)
//   o_bitDone  : strobe on the decision count
//   o_bitEnd   : strobe on the last count of the bit period
// ============================================================================
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_rx,
    input  logic i_start,
    input  logic i_clear,
    input  logic i_run,
    output logic o_bitVal,
    output logic o_bitDone,
    output logic o_bitEnd
);

    localparam int CW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;

    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_S0     = CW'(sampleFirst(OVERSAMPLE));
    localparam logic [CW-1:0] CNT_S1     = CW'(sampleMid(OVERSAMPLE));
    localparam logic [CW-1:0] CNT_DECIDE = CW'(decideCount(OVERSAMPLE));
    localparam logic [CW-1:0] CNT_LAST   = CW'(OVERSAMPLE - 1);

    logic [CW-1:0] r_cnt;
    logic          r_s0;
    logic          r_s1;

    // Bit-period counter. Clearing on return to idle has priority so a frame
    // ending on the stop-bit decision leaves the counter ready for the next
    // start edge, which loads 1 because the edge cycle itself is count 0.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_start) begin
            r_cnt <= CNT_ONE;
        end else if (i_run) begin
            r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_ONE;
        end
    end

    // The first two votes are captured here; the third is the live line
    // value on the decision count, so the decision is known on that edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s0 <= 1'b1;
            r_s1 <= 1'b1;
        end else begin
            if (i_run && (r_cnt == CNT_S0)) begin
                r_s0 <= i_rx;
            end
            if (i_run && (r_cnt == CNT_S1)) begin
                r_s1 <= i_rx;
            end
        end
    end

    assign o_bitVal  = (r_s0 & r_s1) | (r_s0 & i_rx) | (r_s1 & i_rx);
    assign o_bitDone = i_run && (r_cnt == CNT_DECIDE);
    assign o_bitEnd  = i_run && (r_cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx_top.sv
// ============================================================================
// uart_rx_top
// UART receiver: synchronizes the serial line, recovers start/data/parity/
// stop bits using an oversampled majority vote, and presents each good data
// word with a one-cycle valid strobe, or one-cycle error strobes otherwise.
// Ports:
//   CLK_TOP        : clock, rising edge
//   RST_TOP        : synchronous active-high reset
//   RX_IN_TOP      : asynchronous serial line, idles high
//   PAR_EN_TOP     : 1 = frame carries a parity bit (latched at frame start)
//   PAR_TYP_TOP    : 0 = even, 1 = odd parity (latched at frame start)
//   P_DATA_TOP     : last good data word, held between valid strobes
//   DATA_VALID_TOP : one-cycle strobe, good frame on P_DATA_TOP
//   PAR_ERR_TOP    : one-cycle strobe, parity mismatch
//   STP_ERR_TOP    : one-cycle strobe, stop bit sampled low
// ============================================================================
module uart_rx_top
    import uart_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int OVERSAMPLE = 8
) (
    input  logic             CLK_TOP,
    input  logic             RST_TOP,
    input  logic             RX_IN_TOP,
    input  logic             PAR_EN_TOP,
    input  logic             PAR_TYP_TOP,
    output logic [WIDTH-1:0] P_DATA_TOP,
    output logic             DATA_VALID_TOP,
    output logic             PAR_ERR_TOP,
    output logic             STP_ERR_TOP
);

    localparam int             IW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0]  IDX_LAST = IW'(WIDTH - 1);
    localparam logic [IW-1:0]  IDX_ONE  = IW'(1);

    logic             r_sync1;
    logic             r_sync2;
    logic             w_rxS;

    rx_state_t        r_state;
    rx_state_t        w_nextState;
    logic             w_startFrame;
    logic             w_goIdle;
    logic             w_run;

    logic             w_bitVal;
    logic             w_bitDone;
    logic             w_bitEnd;

    logic             r_parEn;
    logic             r_parTyp;
    logic             r_parErr;
    logic [IW-1:0]    r_bitIdx;
    logic [WIDTH-1:0] r_shift;
    logic             w_parExpected;

    // Two-flop synchronizer; both stages reset high so reset never looks
    // like a start edge.
    always_ff @(posedge CLK_TOP) begin
        if (RST_TOP) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= RX_IN_TOP;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rxS = r_sync2;
    assign w_run = (r_state != IDLE);

    uart_rx_sampler #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_sampler (
        .i_clk      (CLK_TOP),
        .i_rst      (RST_TOP),
        .i_rx       (w_rxS),
        .i_start    (w_startFrame),
        .i_clear    (w_goIdle),
        .i_run      (w_run),
        .o_bitVal   (w_bitVal),
        .o_bitDone  (w_bitDone),
        .o_bitEnd   (w_bitEnd)
    );

    // State register
    always_ff @(posedge CLK_TOP) begin
        if (RST_TOP) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. Leaving STOP on the decision count rather than at the
    // end of the bit lets a start edge in the second half of the stop bit be
    // caught, which is what keeps back-to-back frames aligned.
    always_comb begin
        w_nextState  = r_state;
        w_startFrame = 1'b0;
        w_goIdle     = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_rxS) begin
                    w_nextState  = START;
                    w_startFrame = 1'b1;
                end
            end
            START: begin
                if (w_bitDone && w_bitVal) begin
                    w_nextState = IDLE;
                    w_goIdle    = 1'b1;
                end else if (w_bitEnd) begin
                    w_nextState = DATA;
                end
            end
            DATA: begin
                if (w_bitEnd && (r_bitIdx == IDX_LAST)) begin
                    w_nextState = r_parEn ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (w_bitEnd) begin
                    w_nextState = STOP;
                end
            end
            STOP: begin
                if (w_bitDone) begin
                    w_nextState = IDLE;
                    w_goIdle    = 1'b1;
                end
            end
            default: begin
                w_nextState = IDLE;
                w_goIdle    = 1'b1;
            end
        endcase
    end

    assign w_parExpected = (^r_shift) ^ (r_parTyp == PAR_ODD);

    // Per-frame datapath: parity mode is frozen at the start edge so changes
    // on the inputs mid-frame have no effect. Data arrives LSB first, so
    // each decided bit enters at the top and moves down.
    always_ff @(posedge CLK_TOP) begin
        if (RST_TOP) begin
            r_parEn  <= 1'b0;
            r_parTyp <= PAR_EVEN;
            r_parErr <= 1'b0;
            r_bitIdx <= '0;
            r_shift  <= '0;
        end else begin
            if (w_startFrame) begin
                r_parEn  <= PAR_EN_TOP;
                r_parTyp <= PAR_TYP_TOP;
                r_parErr <= 1'b0;
                r_bitIdx <= '0;
            end
            if ((r_state == DATA) && w_bitDone) begin
                r_shift <= WIDTH'({w_bitVal, r_shift} >> 1);
            end
            if ((r_state == DATA) && w_bitEnd) begin
                r_bitIdx <= r_bitIdx + IDX_ONE;
            end
            if ((r_state == PARITY) && w_bitDone) begin
                r_parErr <= (w_bitVal != w_parExpected);
            end
        end
    end

    // Registered outputs. Strobes default low every cycle; the stop-bit
    // decision produces the frame result, and the data word only moves on
    // a fully good frame.
    always_ff @(posedge CLK_TOP) begin
        if (RST_TOP) begin
            P_DATA_TOP     <= '0;
            DATA_VALID_TOP <= 1'b0;
            PAR_ERR_TOP    <= 1'b0;
            STP_ERR_TOP    <= 1'b0;
        end else begin
            DATA_VALID_TOP <= 1'b0;
            PAR_ERR_TOP    <= 1'b0;
            STP_ERR_TOP    <= 1'b0;
            if ((r_state == STOP) && w_bitDone) begin
                PAR_ERR_TOP <= r_parErr;
                STP_ERR_TOP <= !w_bitVal;
                if (w_bitVal && !r_parErr) begin
                    DATA_VALID_TOP <= 1'b1;
                    P_DATA_TOP     <= r_shift;
                end
            end
        end
    end

endmodule
